// File: rtl/axis_frame_gen_pkg.sv
// Shared types and payload formatting for the AXI-Stream frame generator.
package axis_frame_gen_pkg;

  // Widest tdata the payload builder can format.
  localparam int unsigned PAYLOAD_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'd0,
    MODE_FIXED = 2'd1,
    MODE_HDR   = 2'd2
  } mode_t;

  // Inputs arrive zero-extended; the caller truncates the result to its tdata width.
  function automatic logic [PAYLOAD_W-1:0] build_payload(
    input logic [1:0]           mode,
    input logic [PAYLOAD_W-1:0] fixed,
    input logic [PAYLOAD_W-1:0] dest,
    input logic [7:0]           frame_idx,
    input logic [PAYLOAD_W-1:0] cnt,
    input int unsigned          cntr_w
  );
    logic [PAYLOAD_W-1:0] p;
    case (mode)
      MODE_FIXED: p = (fixed << cntr_w) | cnt;
      MODE_HDR:   p = (dest << (cntr_w + 8)) | (PAYLOAD_W'(frame_idx) << cntr_w) | cnt;
      default:    p = cnt;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/axis_frame_gen.sv
// Runtime-configurable AXI-Stream frame generator: counted or continuous runs of
// fixed-length frames with programmable gaps and round-robin tdest.
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNTR_WIDTH = 8,
  parameter int unsigned DEST_WIDTH = 4,
  parameter int unsigned NUM_DEST   = 2,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned GAP_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           stop,
  input  logic [15:0]                    num_frames,
  input  logic [LEN_WIDTH-1:0]           frame_len,
  input  logic [GAP_WIDTH-1:0]           gap_cycles,
  input  logic [1:0]                     mode,
  input  logic [DATA_WIDTH-CNTR_WIDTH-1:0] fixed_data,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    frames_sent,
  output logic [DATA_WIDTH-1:0]          M_AXIS_tdata,
  output logic [DEST_WIDTH-1:0]          M_AXIS_tdest,
  output logic [DATA_WIDTH/8-1:0]        M_AXIS_tkeep,
  output logic                           M_AXIS_tlast,
  output logic                           M_AXIS_tvalid,
  input  logic                           M_AXIS_tready
);

  localparam int unsigned KEEP_W  = DATA_WIDTH / 8;
  localparam int unsigned FIX_W   = DATA_WIDTH - CNTR_WIDTH;
  localparam int unsigned DEST_CW = DEST_WIDTH + 1;
  localparam logic [DEST_WIDTH:0] DEST_LAST = DEST_CW'(NUM_DEST - 1);

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $fatal(1, "DATA_WIDTH must be a multiple of 8");
  end
  if (CNTR_WIDTH + DEST_WIDTH + 8 > DATA_WIDTH) begin : g_bad_cntr_width
    $fatal(1, "CNTR_WIDTH must be <= DATA_WIDTH - DEST_WIDTH - 8");
  end
  if (NUM_DEST < 1 || NUM_DEST > (1 << DEST_WIDTH)) begin : g_bad_num_dest
    $fatal(1, "NUM_DEST must be in 1..2**DEST_WIDTH");
  end
  if (DATA_WIDTH > PAYLOAD_W) begin : g_bad_payload_width
    $fatal(1, "DATA_WIDTH exceeds payload builder width");
  end

  function automatic logic [DATA_WIDTH-1:0] payload(
    input logic [1:0]            m,
    input logic [FIX_W-1:0]      fixed,
    input logic [DEST_WIDTH-1:0] dest,
    input logic [7:0]            fidx,
    input logic [CNTR_WIDTH-1:0] cnt
  );
    return DATA_WIDTH'(build_payload(m, PAYLOAD_W'(fixed), PAYLOAD_W'(dest), fidx,
                                     PAYLOAD_W'(cnt), CNTR_WIDTH));
  endfunction

  state_t                  r_state, w_state_nxt;
  logic [15:0]             r_num_frames;
  logic [LEN_WIDTH-1:0]    r_last_beat;
  logic [GAP_WIDTH-1:0]    r_gap;
  logic [1:0]              r_mode;
  logic [FIX_W-1:0]        r_fixed;
  logic                    w_cfg_load;

  logic [LEN_WIDTH-1:0]    r_beat, w_beat_nxt;
  logic [CNTR_WIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [DEST_WIDTH-1:0]   r_dest, w_dest_nxt;
  logic [GAP_WIDTH-1:0]    r_gap_cnt, w_gap_cnt_nxt;
  logic [15:0]             r_frames_sent, w_sent_nxt;
  logic                    r_stop_seen, w_stop_nxt;
  logic                    r_busy, w_busy_nxt;
  logic                    r_done, w_done_nxt;
  logic                    r_tvalid, w_tvalid_nxt;
  logic                    r_tlast, w_tlast_nxt;
  logic [DATA_WIDTH-1:0]   r_tdata, w_tdata_nxt;
  logic [DEST_WIDTH-1:0]   r_tdest, w_tdest_nxt;

  logic                    w_xfer;
  logic [LEN_WIDTH-1:0]    w_len_m1_in;
  logic [DEST_WIDTH-1:0]   w_dest_inc;
  logic [15:0]             w_sent_inc;
  logic                    w_run_end;

  // A zero frame length is treated as a single-beat frame.
  assign w_len_m1_in = (frame_len == '0) ? '0 : frame_len - LEN_WIDTH'(1);
  assign w_xfer      = r_tvalid & M_AXIS_tready;
  assign w_dest_inc  = ({1'b0, r_dest} == DEST_LAST) ? '0 : r_dest + DEST_WIDTH'(1);
  assign w_sent_inc  = r_frames_sent + 16'd1;
  assign w_run_end   = r_stop_seen | stop |
                       ((r_num_frames != '0) && (w_sent_inc == r_num_frames));

  // Next-state and next-beat computation.
  always_comb begin
    w_state_nxt   = r_state;
    w_cfg_load    = 1'b0;
    w_beat_nxt    = r_beat;
    w_cnt_nxt     = r_cnt;
    w_dest_nxt    = r_dest;
    w_gap_cnt_nxt = r_gap_cnt;
    w_sent_nxt    = r_frames_sent;
    w_stop_nxt    = r_stop_seen;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_tvalid_nxt  = r_tvalid;
    w_tlast_nxt   = r_tlast;
    w_tdata_nxt   = r_tdata;
    w_tdest_nxt   = r_tdest;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt  = SEND;
          w_cfg_load   = 1'b1;
          w_busy_nxt   = 1'b1;
          w_beat_nxt   = '0;
          w_cnt_nxt    = '0;
          w_dest_nxt   = '0;
          w_sent_nxt   = '0;
          w_stop_nxt   = 1'b0;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = (w_len_m1_in == '0);
          w_tdata_nxt  = payload(mode, fixed_data, '0, 8'd0, '0);
          w_tdest_nxt  = '0;
        end
      end

      SEND: begin
        w_stop_nxt = r_stop_seen | stop;
        if (w_xfer) begin
          if (r_tlast) begin
            w_sent_nxt = w_sent_inc;
            w_beat_nxt = '0;
            w_cnt_nxt  = '0;
            w_stop_nxt = 1'b0;
            w_dest_nxt = w_dest_inc;
            if (w_run_end) begin
              w_state_nxt  = DONE;
              w_busy_nxt   = 1'b0;
              w_done_nxt   = 1'b1;
              w_tvalid_nxt = 1'b0;
              w_tlast_nxt  = 1'b0;
              w_tdata_nxt  = '0;
              w_tdest_nxt  = '0;
            end else if (r_gap == '0) begin
              w_tvalid_nxt = 1'b1;
              w_tlast_nxt  = (r_last_beat == '0);
              w_tdata_nxt  = payload(r_mode, r_fixed, w_dest_inc, w_sent_inc[7:0], '0);
              w_tdest_nxt  = w_dest_inc;
            end else begin
              w_state_nxt   = GAP;
              w_gap_cnt_nxt = r_gap;
              w_tvalid_nxt  = 1'b0;
              w_tlast_nxt   = 1'b0;
              w_tdata_nxt   = '0;
              w_tdest_nxt   = '0;
            end
          end else begin
            w_beat_nxt  = r_beat + LEN_WIDTH'(1);
            w_cnt_nxt   = r_cnt + CNTR_WIDTH'(1);
            w_tlast_nxt = ((r_beat + LEN_WIDTH'(1)) == r_last_beat);
            w_tdata_nxt = payload(r_mode, r_fixed, r_dest, r_frames_sent[7:0],
                                  r_cnt + CNTR_WIDTH'(1));
          end
        end
      end

      // The last gap cycle decides between the next frame and ending on a pending stop.
      GAP: begin
        w_stop_nxt = r_stop_seen | stop;
        if (r_gap_cnt != GAP_WIDTH'(1)) begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_WIDTH'(1);
        end else if (r_stop_seen | stop) begin
          w_state_nxt = DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_stop_nxt  = 1'b0;
        end else begin
          w_state_nxt  = SEND;
          w_tvalid_nxt = 1'b1;
          w_tlast_nxt  = (r_last_beat == '0);
          w_tdata_nxt  = payload(r_mode, r_fixed, r_dest, r_frames_sent[7:0], '0);
          w_tdest_nxt  = r_dest;
        end
      end

      DONE: w_state_nxt = IDLE;

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_beat        <= '0;
      r_cnt         <= '0;
      r_dest        <= '0;
      r_gap_cnt     <= '0;
      r_frames_sent <= '0;
      r_stop_seen   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tdata       <= '0;
      r_tdest       <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_beat        <= w_beat_nxt;
      r_cnt         <= w_cnt_nxt;
      r_dest        <= w_dest_nxt;
      r_gap_cnt     <= w_gap_cnt_nxt;
      r_frames_sent <= w_sent_nxt;
      r_stop_seen   <= w_stop_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_tvalid      <= w_tvalid_nxt;
      r_tlast       <= w_tlast_nxt;
      r_tdata       <= w_tdata_nxt;
      r_tdest       <= w_tdest_nxt;
    end
  end

  // Run configuration is captured only when a run starts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_frames <= '0;
      r_last_beat  <= '0;
      r_gap        <= '0;
      r_mode       <= '0;
      r_fixed      <= '0;
    end else if (w_cfg_load) begin
      r_num_frames <= num_frames;
      r_last_beat  <= w_len_m1_in;
      r_gap        <= gap_cycles;
      r_mode       <= mode;
      r_fixed      <= fixed_data;
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign frames_sent   = r_frames_sent;
  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tdest  = r_tdest;
  assign M_AXIS_tkeep  = {KEEP_W{r_tvalid}};
  assign M_AXIS_tlast  = r_tlast;
  assign M_AXIS_tvalid = r_tvalid;

endmodule
